mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the data and address width, matching the memory data port.
REQ-002 The block SHALL have parameter DSEG_DEPTH, default 32, which is the number of words in the data segment; legal addresses are 0..DSEG_DEPTH-1.
REQ-003 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high: clk in 1 is the clock; rst in 1 is the reset.
REQ-004 The block SHALL have these requester ports, k = 0 (pipeline memory stage) and k = 1 (loader/debug port):
- reqk in 1: access request.
- wek in 1: 1 = write, 0 = read.
- addrk in WIDTH: data-segment word address.
- wdatak in WIDTH: write data.
- gntk out 1: request accepted.
- rvalidk out 1: response valid.
- rdatak out WIDTH: read data.
- errk out 1: address out of range, qualified by rvalidk.
REQ-005 The block SHALL have these memory-side ports:
- mem_we out 1: drives the memory write enable.
- mem_a out WIDTH: drives the data-segment address.
- mem_wd out WIDTH: drives the write data.
- mem_rd in WIDTH: combinational read data from the memory.

Function
REQ-006 The block SHALL implement an FSM with states IDLE, SERVE and RESP.
REQ-007 In IDLE or RESP, if any reqk is high, the FSM SHALL select a winner, latch its we, addr and wdata, assert its gntk for exactly one cycle, and go to SERVE on the next edge.
REQ-008 If no reqk is high in IDLE or RESP, the FSM SHALL go to (or stay in) IDLE.
REQ-009 gntk SHALL be combinational in the cycle the request is sampled; the requester SHALL hold reqk, wek, addrk and wdatak stable until gntk.
REQ-010 A requester MAY drop reqk before grant; a dropped request SHALL be ignored with no side effects.
REQ-011 In SERVE, mem_a SHALL equal the latched address and mem_wd SHALL equal the latched write data.
REQ-012 In SERVE, mem_we SHALL equal latched we AND (latched address < DSEG_DEPTH).
REQ-013 mem_we SHALL be 0 in every state other than SERVE.
REQ-014 In SERVE, rdata SHALL be captured from mem_rd for a read, 0 for a write, and 0 when out of range; the FSM SHALL then go to RESP.
REQ-015 In RESP, rvalidk of the served port SHALL be high for exactly one cycle, with rdatak valid.
REQ-016 In RESP, errk SHALL be 1 if the latched address was >= DSEG_DEPTH.
REQ-017 rdatak SHALL hold its value until the next response to that port.
REQ-018 Latency SHALL be: grant in cycle N, memory access in cycle N+1, rvalidk in cycle N+2.
REQ-019 Back-to-back service SHALL be possible: grant in RESP overlaps the previous response, giving one access every 2 cycles.
REQ-020 When req0 and req1 are high in the same cycle, the arbitration policy SHALL be as set by REQ-026.
REQ-021 At most one gntk and at most one rvalidk SHALL be high in any cycle.
REQ-022 Address comparison SHALL be unsigned at full WIDTH, so 0xFFFF is out of range.
REQ-023 A write to an out-of-range address SHALL NOT modify memory.

Reset
REQ-024 While rst is high, the FSM SHALL be in IDLE, and gnt0/1, rvalid0/1, err0/1, mem_we and the round-robin pointer SHALL be 0.
REQ-025 While rst is high, rdata0/1, mem_a and mem_wd SHALL be 0; an access in flight when rst rises SHALL be aborted with no write and no response.

Configuration
REQ-026 Arbitration SHALL be selected by macro MEM_ARBITER_ROUND_ROBIN_EN:
- When defined: round-robin; a 1-bit pointer names the preferred port; after each grant the pointer moves to the other port; reset value is port 0.
- When undefined: fixed priority; port 0 always wins a tie; no pointer register exists.

Verification
REQ-027 Reset then idle: rst pulse, no requests -> all outputs 0; mem_we never asserted.
REQ-028 Write then read: port0 writes 0xBEEF to addr 5, then reads addr 5 -> gnt0 at N, mem_we=1 with mem_a=5 at N+1, rvalid0 at N+2; the read returns rdata0=0xBEEF, err0=0.
REQ-029 Simultaneous requests for 4 rounds: req0 and req1 held high -> with the macro, grant order 0,1,0,1; without it, 0,0,0,0 and port1 starved.
REQ-030 Out of range: port1 writes 0x1234 to addr 32 (DSEG_DEPTH=32) -> mem_we stays 0, rvalid1=1, err1=1, rdata1=0, and memory is unchanged.
REQ-031 Mid-access reset: rst asserted during SERVE of a write -> no rvalid, FSM in IDLE; after release, a read of that address returns its prior value.
REQ-032 Withdrawn request: req1 pulsed for 1 cycle while port0 is being served -> no gnt1, no rvalid1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a combinational-read data memory.
// The slave modport is the arbiter. The master modport is the requesters plus the memory.
interface mem_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0, we0, gnt0, rvalid0, err0;
    logic [WIDTH-1:0] addr0, wdata0, rdata0;
    logic             req1, we1, gnt1, rvalid1, err1;
    logic [WIDTH-1:0] addr1, wdata1, rdata1;
    logic             mem_we;
    logic [WIDTH-1:0] mem_a, mem_wd, mem_rd;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd,
        output gnt0, rvalid0, rdata0, err0, gnt1, rvalid1, rdata1, err1,
        output mem_we, mem_a, mem_wd
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd,
        input  gnt0, rvalid0, rdata0, err0, gnt1, rvalid1, rdata1, err1,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port data-segment arbiter: grant, then one memory access, then one response cycle.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int WIDTH      = 16,
    parameter int DSEG_DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DSEG_DEPTH);

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    state_t           state_reg;
    logic             sel_reg;
    logic             we_reg;
    logic             err_reg;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [WIDTH-1:0] rdata0_reg;
    logic [WIDTH-1:0] rdata1_reg;

    logic             any_req;
    logic             accept;
    logic             win;
    logic             in_range;
    logic [WIDTH-1:0] rd_next;

    assign any_req  = bus.req0 | bus.req1;
    assign accept   = any_req && ((state_reg == IDLE) || (state_reg == RESP));
    assign in_range = addr_reg < DEPTH_W;
    assign rd_next  = (!we_reg && in_range) ? bus.mem_rd : '0;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic ptr_reg;
    // On a tie the pointer picks the port; otherwise the only requester wins.
    assign win = (bus.req0 && bus.req1) ? ptr_reg : bus.req1;
`else
    assign win = !bus.req0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            sel_reg    <= 1'b0;
            we_reg     <= 1'b0;
            err_reg    <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata0_reg <= '0;
            rdata1_reg <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            ptr_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, RESP: begin
                    if (any_req) begin
                        sel_reg   <= win;
                        we_reg    <= win ? bus.we1    : bus.we0;
                        addr_reg  <= win ? bus.addr1  : bus.addr0;
                        wdata_reg <= win ? bus.wdata1 : bus.wdata0;
                        state_reg <= SERVE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        ptr_reg   <= ~win;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SERVE: begin
                    err_reg <= !in_range;
                    if (sel_reg) rdata1_reg <= rd_next;
                    else         rdata0_reg <= rd_next;
                    state_reg <= RESP;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt0    = accept && !win;
    assign bus.gnt1    = accept && win;
    assign bus.rvalid0 = (state_reg == RESP) && !sel_reg;
    assign bus.rvalid1 = (state_reg == RESP) && sel_reg;
    assign bus.err0    = bus.rvalid0 && err_reg;
    assign bus.err1    = bus.rvalid1 && err_reg;
    assign bus.rdata0  = rdata0_reg;
    assign bus.rdata1  = rdata1_reg;

    // Out-of-range writes never reach the memory, so aliasing memories stay intact.
    assign bus.mem_we  = (state_reg == SERVE) && we_reg && in_range;
    assign bus.mem_a   = addr_reg;
    assign bus.mem_wd  = wdata_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected responses, a negedge monitor checks them.
// A 32-word memory model that aliases on the low address bits stands in for the data segment.
module tb_mem_arbiter;
    localparam int WIDTH = 16;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mem_arbiter #(.WIDTH(WIDTH), .DSEG_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] mem_model [DEPTH];
    assign bus.mem_rd = mem_model[bus.mem_a[4:0]];
    always @(posedge clk) if (bus.mem_we) mem_model[bus.mem_a[4:0]] <= bus.mem_wd;

    typedef struct {
        logic             port;
        logic [WIDTH-1:0] rdata;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mem_we_cnt = 0;
    int   gnt1_cnt = 0;
    int   rv1_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we) mem_we_cnt++;
            if (bus.gnt1) gnt1_cnt++;
            if (bus.rvalid1) rv1_cnt++;
            if (bus.gnt0 && bus.gnt1) check("one_gnt", 32'd2, 32'd1);
            if (bus.rvalid0 && bus.rvalid1) check("one_rvalid", 32'd2, 32'd1);
            if (bus.rvalid0 || bus.rvalid1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_port", {31'd0, bus.rvalid1}, {31'd0, mon_e.port});
                    if (mon_e.port) begin
                        check("resp_rdata1", {16'd0, bus.rdata1}, {16'd0, mon_e.rdata});
                        check("resp_err1", {31'd0, bus.err1}, {31'd0, mon_e.err});
                    end else begin
                        check("resp_rdata0", {16'd0, bus.rdata0}, {16'd0, mon_e.rdata});
                        check("resp_err0", {31'd0, bus.err0}, {31'd0, mon_e.err});
                    end
                end
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that accepts the grant (DUT in SERVE).
    task automatic access(input logic port, input logic we, input logic [WIDTH-1:0] addr,
                          input logic [WIDTH-1:0] wdata, input logic [WIDTH-1:0] exp_rd,
                          input logic exp_err, input logic push);
        exp_t e;
        bit   got = 0;
        drive(port, 1'b1, we, addr, wdata);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (port ? bus.gnt1 : bus.gnt0) begin
                got = 1;
                e.port = port; e.rdata = exp_rd; e.err = exp_err;
                if (push) exp_q.push_back(e);
            end
        end
        if (!got) check("grant_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gnt_rvalid_err", {26'd0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}, 32'd0);
        check("rst_rdata", {bus.rdata1, bus.rdata0}, 32'd0);
        check("rst_mem", {15'd0, bus.mem_we, bus.mem_a}, 32'd0);
        check("rst_mem_wd", {16'd0, bus.mem_wd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [3:0] exp_order;
    int         ngr;
    exp_t       e2;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'hA000 + 16'(i);
        do_reset();

        // Idle after reset
        mem_we_cnt = 0;
        repeat (5) @(negedge clk);
        check("idle_mem_we", mem_we_cnt, 0);
        check("idle_outputs", {30'd0, bus.gnt0 | bus.gnt1, bus.rvalid0 | bus.rvalid1}, 32'd0);
        @(posedge clk); #1;

        // Write 0xBEEF to 5 with latency checks, then read it back
        access(1'b0, 1'b1, 16'd5, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        check("wr_mem_we_n1", {31'd0, bus.mem_we}, 32'd1);
        check("wr_mem_a_n1", {16'd0, bus.mem_a}, 32'd5);
        check("wr_mem_wd_n1", {16'd0, bus.mem_wd}, 32'h0000BEEF);
        @(negedge clk);
        check("wr_rvalid0_n2", {31'd0, bus.rvalid0}, 32'd1);
        check("wr_mem_we_n2", {31'd0, bus.mem_we}, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 1'b0, 16'd5, '0, 16'hBEEF, 1'b0, 1'b1);
        access(1'b1, 1'b1, 16'd7, 16'h7777, 16'h0000, 1'b0, 1'b1);
        access(1'b1, 1'b0, 16'd7, '0, 16'h7777, 1'b0, 1'b1);
        access(1'b0, 1'b0, 16'd31, '0, 16'hA01F, 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Out-of-range write and full-width address
        mem_we_cnt = 0;
        access(1'b1, 1'b1, 16'd32, 16'h1234, 16'h0000, 1'b1, 1'b1);
        repeat (2) @(posedge clk); #1;
        check("oor_mem_we", mem_we_cnt, 0);
        access(1'b0, 1'b0, 16'hFFFF, '0, 16'h0000, 1'b1, 1'b1);
        access(1'b0, 1'b0, 16'd0, '0, 16'hA000, 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Withdrawn request from port 1 while port 0 is served
        gnt1_cnt = 0;
        rv1_cnt  = 0;
        access(1'b0, 1'b0, 16'd5, '0, 16'hBEEF, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 16'd3, 16'hDEAD);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clk); #1;
        check("withdrawn_gnt1", gnt1_cnt, 0);
        check("withdrawn_rvalid1", rv1_cnt, 0);
        access(1'b0, 1'b0, 16'd3, '0, 16'hA003, 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Mid-access reset: write to 9 is aborted
        access(1'b0, 1'b1, 16'd9, 16'h5555, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("abort_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
        do_reset();
        access(1'b0, 1'b0, 16'd9, '0, 16'hA009, 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Simultaneous requests for 4 rounds, from a freshly reset pointer
        do_reset();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        drive(1'b0, 1'b1, 1'b0, 16'd5, '0);
        drive(1'b1, 1'b1, 1'b0, 16'd7, '0);
        ngr = 0;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                check($sformatf("tie_grant_%0d", ngr), {31'd0, bus.gnt1}, {31'd0, exp_order[ngr]});
                e2.port  = bus.gnt1;
                e2.rdata = bus.gnt1 ? 16'h7777 : 16'hBEEF;
                e2.err   = 1'b0;
                exp_q.push_back(e2);
                ngr++;
            end
        end
        if (ngr < 4) check("tie_grant_timeout", ngr, 4);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clk); #1;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
